// File: rtl/crc32_hash.sv
// Single-word CRC-32 (IEEE 802.3, reflected) step with a combinational result
// and an optional one-cycle registered copy for pipelined users.
module crc32_hash (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] state_in,
  input  logic [31:0] data_in,
  output logic [31:0] state_out,
  input  logic        valid_i,
  output logic        valid_o,
  output logic [31:0] state_q_o
);

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  // Bit k of the word is consumed at step k, which gives byte [7:0] first, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] s_init,
                                           input logic [31:0] d);
    logic [31:0] s;
    logic        fb;
    s = s_init;
    for (int k = 0; k < 32; k++) begin
      fb = s[0] ^ d[k];
      s  = (s >> 1) ^ (fb ? CRC_POLY_REFL : 32'h0000_0000);
    end
    return s;
  endfunction

  always_comb begin
    state_out = crc_step(state_in, data_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o   <= 1'b0;
      state_q_o <= 32'hFFFF_FFFF;
    end else if (valid_i) begin
      valid_o   <= 1'b1;
      state_q_o <= state_out;
    end else begin
      valid_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc32_hash.sv
// Directed bench for crc32_hash: known CRC-32 vectors, chaining, linearity,
// a bit-serial reference sweep, and the registered path around reset.
module tb_crc32_hash;

  logic        clk;
  logic        rst;
  logic [31:0] state_in;
  logic [31:0] data_in;
  logic [31:0] state_out;
  logic        valid_i;
  logic        valid_o;
  logic [31:0] state_q_o;

  int total = 0;
  int bad   = 0;

  crc32_hash dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .data_in   (data_in),
    .state_out (state_out),
    .valid_i   (valid_i),
    .valid_o   (valid_o),
    .state_q_o (state_q_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_crc(input logic [31:0] s_init, input logic [31:0] d);
    logic [31:0] s;
    s = s_init;
    for (int k = 0; k < 32; k++) begin
      if (s[0] ^ d[k]) s = (s >> 1) ^ 32'hEDB88320;
      else             s = s >> 1;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; state_in = 32'hFFFF_FFFF; data_in = 32'h0;
    tick();
    tick();
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%0b want=0", valid_o);
    end
    total++;
    if (state_q_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL reset_state_q got=%08h want=FFFFFFFF", state_q_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_vectors();
    state_in = 32'hFFFF_FFFF; data_in = 32'h0000_0000; #1;
    total++;
    if (state_out !== 32'hDEBB20E3) begin
      bad++; $display("FAIL crc_zero got=%08h want=DEBB20E3", state_out);
    end
    total++;
    if (state_out[4:0] !== 5'h03) begin
      bad++; $display("FAIL hash_index got=%02h want=03", state_out[4:0]);
    end
    data_in = 32'h3433_3231; #1;
    total++;
    if (state_out !== 32'h641C1F5C) begin
      bad++; $display("FAIL crc_1234 got=%08h want=641C1F5C", state_out);
    end
    total++;
    if (~state_out !== 32'h9BE3E0A3) begin
      bad++; $display("FAIL crc_1234_inv got=%08h want=9BE3E0A3", ~state_out);
    end
    state_in = 32'h0; data_in = 32'h0; #1;
    total++;
    if (state_out !== 32'h0) begin
      bad++; $display("FAIL crc_all_zero got=%08h want=00000000", state_out);
    end
    // f(0,d) = f(FFFFFFFF,d) ^ f(FFFFFFFF,0) = 641C1F5C ^ DEBB20E3
    data_in = 32'h3433_3231; #1;
    total++;
    if (state_out !== 32'hBAA73FBF) begin
      bad++; $display("FAIL crc_zero_state got=%08h want=BAA73FBF", state_out);
    end
  endtask

  task automatic test_chaining();
    logic [31:0] mid;
    state_in = 32'hFFFF_FFFF; data_in = 32'h3433_3231; #1;
    mid = state_out;
    state_in = mid; data_in = 32'h3837_3635; #1;
    total++;
    if (~state_out !== 32'h9AE0DAAF) begin
      bad++; $display("FAIL chain_12345678 got=%08h want=9AE0DAAF", ~state_out);
    end
  endtask

  task automatic test_linearity();
    logic [31:0] s, d, f_sd, f_s0, f_0d;
    for (int i = 0; i < 200; i++) begin
      s = $urandom; d = $urandom;
      state_in = s; data_in = d;   #1; f_sd = state_out;
      state_in = s; data_in = 0;   #1; f_s0 = state_out;
      state_in = 0; data_in = d;   #1; f_0d = state_out;
      total++;
      if (f_sd !== (f_s0 ^ f_0d)) begin
        bad++; $display("FAIL linearity s=%08h d=%08h got=%08h want=%08h", s, d, f_sd, f_s0 ^ f_0d);
      end
    end
  endtask

  task automatic test_reference_sweep();
    logic [31:0] exp;
    for (int i = 0; i < 10000; i++) begin
      state_in = $urandom; data_in = $urandom; #1;
      exp = ref_crc(state_in, data_in);
      total++;
      if (state_out !== exp) begin
        bad++; $display("FAIL ref_model s=%08h d=%08h got=%08h want=%08h", state_in, data_in, state_out, exp);
      end
    end
  endtask

  task automatic test_registered();
    state_in = 32'hFFFF_FFFF; data_in = 32'h0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || state_q_o !== 32'hDEBB20E3) begin
      bad++; $display("FAIL reg_capture got=%0b/%08h want=1/DEBB20E3", valid_o, state_q_o);
    end
    data_in = 32'h3433_3231;
    tick();
    total++;
    if (valid_o !== 1'b0 || state_q_o !== 32'hDEBB20E3) begin
      bad++; $display("FAIL reg_hold got=%0b/%08h want=0/DEBB20E3", valid_o, state_q_o);
    end
  endtask

  task automatic test_back_to_back();
    state_in = 32'hFFFF_FFFF; data_in = 32'h0; valid_i = 1'b1;
    tick();
    total++;
    if (valid_o !== 1'b1 || state_q_o !== 32'hDEBB20E3) begin
      bad++; $display("FAIL b2b_first got=%0b/%08h want=1/DEBB20E3", valid_o, state_q_o);
    end
    data_in = 32'h3433_3231;
    tick();
    total++;
    if (valid_o !== 1'b1 || state_q_o !== 32'h641C1F5C) begin
      bad++; $display("FAIL b2b_second got=%0b/%08h want=1/641C1F5C", valid_o, state_q_o);
    end
    valid_i = 1'b0;
    tick();
    total++;
    if (valid_o !== 1'b0 || state_q_o !== 32'h641C1F5C) begin
      bad++; $display("FAIL b2b_idle got=%0b/%08h want=0/641C1F5C", valid_o, state_q_o);
    end
  endtask

  task automatic test_reset_midstream();
    state_in = 32'hFFFF_FFFF; data_in = 32'h3433_3231; valid_i = 1'b1;
    tick();
    data_in = 32'h0; rst = 1'b1;
    tick();
    total++;
    if (valid_o !== 1'b0 || state_q_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mid_reset got=%0b/%08h want=0/FFFFFFFF", valid_o, state_q_o);
    end
    total++;
    if (state_out !== 32'hDEBB20E3) begin
      bad++; $display("FAIL comb_in_reset got=%08h want=DEBB20E3", state_out);
    end
    rst = 1'b0;
    tick();
    total++;
    if (valid_o !== 1'b1 || state_q_o !== 32'hDEBB20E3) begin
      bad++; $display("FAIL release_capture got=%0b/%08h want=1/DEBB20E3", valid_o, state_q_o);
    end
    valid_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_chaining();
    test_linearity();
    test_reference_sweep();
    test_registered();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
